// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one word-aligned request at a time to instruction memory and
// buffers returned words, tagged with their address, in a 2-entry FIFO.
// A taken branch is reported on the pop of the head. It flushes the buffer
// and retargets fetch. A response that is still in flight at that point is
// drained and dropped in KILL.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_BUSY   = 2'd1;
  localparam logic [1:0]  S_KILL   = 2'd2;
  localparam logic [1:0]  FULL     = 2'(DEPTH);
  localparam logic [31:0] START_PC = RESET_PC & ~32'd3;

  logic [1:0]  r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_raddr;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_pc_mem  [DEPTH];
  logic [31:0] r_ins_mem [DEPTH];

  logic        w_pop;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_push;
  logic        w_wr_idx;
  logic [1:0]  w_cnt_after;
  logic [31:0] w_raddr_nxt;

  assign w_pop       = (r_count != 2'd0) && instr_ready;
  assign w_redirect  = w_pop && PCSrc;
  assign w_target    = PCTarget & ~32'd3;
  assign w_push      = (r_state == S_BUSY) && imem_ack && !w_redirect;
  // Tail slot: head + count (mod 2). A push only happens when count < 2.
  assign w_wr_idx    = r_head ^ r_count[0];
  assign w_cnt_after = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_raddr_nxt = r_raddr + 32'd4;

  // Control state: FSM, fetch/request addresses, FIFO occupancy and head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fpc   <= START_PC;
      r_raddr <= START_PC;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_count <= 2'd0;
      end else begin
        r_count <= w_cnt_after;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            r_fpc <= w_target;
          end else if (r_count < FULL) begin
            r_state <= S_BUSY;
            r_raddr <= r_fpc;
          end
        end
        S_BUSY: begin
          if (w_redirect) begin
            r_fpc   <= w_target;
            r_state <= imem_ack ? S_IDLE : S_KILL;
          end else if (imem_ack) begin
            // raddr advances even when stopping, so an idle unit shows
            // the next fetch address on imem_addr.
            r_fpc   <= w_raddr_nxt;
            r_raddr <= w_raddr_nxt;
            r_state <= (w_cnt_after < FULL) ? S_BUSY : S_IDLE;
          end
        end
        S_KILL: begin
          if (w_redirect) begin
            r_fpc <= w_target;
          end
          if (imem_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage: returned word and its address written at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[w_wr_idx]  <= r_raddr;
      r_ins_mem[w_wr_idx] <= imem_rdata;
    end
  end

  // Outputs decoded from registers only; head fields read as 0 when empty.
  always_comb begin
    imem_req    = (r_state == S_BUSY) || (r_state == S_KILL);
    imem_addr   = r_raddr;
    instr_valid = (r_count != 2'd0);
    Instr       = 32'd0;
    PC          = 32'd0;
    if (r_count != 2'd0) begin
      Instr = r_ins_mem[r_head];
      PC    = r_pc_mem[r_head];
    end
    PCPlus4 = PC + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and scoreboard checks for fetch_unit.
module tb_fetch_unit;

  localparam logic [31:0] TAG = 32'hA5C3_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'd0;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[14];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_ready(instr_ready), .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  always #5 clk = ~clk;

  // Memory model: each word is tagged with its own address.
  assign imem_rdata = imem_addr ^ TAG;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with next-edge inputs set: scores a pop, then advances one cycle.
  task automatic step();
    logic [31:0] e;
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_extra_pop: got PC %h expected no pop", PC);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", PC, e);
        chk("sb_instr", Instr, e ^ TAG);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("sb_drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    PCSrc = 1'b0;
    PCTarget = 32'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd0};
    for (int i = 3; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 32'd8, 1'b1, 32'd0};
    tbl[10] = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd4};
    tbl[11] = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd0};
    tbl[12] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[13] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd12};

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_pc", PC, 32'd0);

    // Backpressure table: ready low for 10 cycles, then released
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr_ready = tbl[i].ready;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("bp%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("bp%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("bp%0d_pc", i), PC, tbl[i].exp_pc);
      chk($sformatf("bp%0d_instr", i), Instr, tbl[i].exp_valid ? (tbl[i].exp_pc ^ TAG) : 32'd0);
      chk($sformatf("bp%0d_pc4", i), PCPlus4, tbl[i].exp_pc + 32'd4);
    end

    // Streaming: latency of first valid, then one instruction per cycle
    do_reset();
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    k = 0;
    while (!instr_valid && k < 10) begin
      step();
      k++;
    end
    chk("first_valid_latency", 32'(k), 32'd2);
    for (int i = 0; i < 20; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("stream_valid%0d", i), 32'(instr_valid), 32'd1);
      step();
    end
    chk("stream_left", 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;

    // Redirect while memory is idle
    do_reset();
    imem_ack = 1'b1;
    repeat (3) step();
    chk("r1_idle_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    instr_ready = 1'b1;
    step();
    PCSrc = 1'b1;
    PCTarget = 32'h100;
    step();
    PCSrc = 1'b0;
    chk("r1_flushed", 32'(instr_valid), 32'd0);
    step();
    chk("r1_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    drain(10);
    instr_ready = 1'b0;

    // Redirect with a request in flight: late word dropped via KILL
    do_reset();
    imem_ack = 1'b1;
    repeat (2) step();
    imem_ack = 1'b0;
    step();
    chk("r2_hold_addr", imem_addr, 32'd4);
    chk("r2_hold_req", 32'(imem_req), 32'd1);
    exp_q.push_back(32'd0);
    instr_ready = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'h200;
    step();
    PCSrc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("r2_kill_req%0d", i), 32'(imem_req), 32'd1);
      chk($sformatf("r2_kill_addr%0d", i), imem_addr, 32'd4);
      chk($sformatf("r2_kill_valid%0d", i), 32'(instr_valid), 32'd0);
      step();
    end
    imem_ack = 1'b1;
    step();
    chk("r2_drop_req", 32'(imem_req), 32'd0);
    chk("r2_drop_valid", 32'(instr_valid), 32'd0);
    step();
    chk("r2_new_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    drain(10);
    instr_ready = 1'b0;

    // Redirect and ack together; unaligned target
    do_reset();
    imem_ack = 1'b1;
    repeat (2) step();
    exp_q.push_back(32'd0);
    instr_ready = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'h203;
    step();
    PCSrc = 1'b0;
    chk("r3_flush_valid", 32'(instr_valid), 32'd0);
    chk("r3_req", 32'(imem_req), 32'd0);
    step();
    chk("r3_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    drain(10);
    instr_ready = 1'b0;

    // Address wrap at the top of memory
    do_reset();
    imem_ack = 1'b1;
    repeat (2) step();
    exp_q.push_back(32'd0);
    instr_ready = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'hFFFF_FFF8;
    step();
    PCSrc = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    drain(12);
    instr_ready = 1'b0;

    // Asynchronous reset while BUSY with a buffered word
    do_reset();
    imem_ack = 1'b1;
    repeat (2) step();
    chk("r4_pre_req", 32'(imem_req), 32'd1);
    chk("r4_pre_valid", 32'(instr_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("r4_async_req", 32'(imem_req), 32'd0);
    chk("r4_async_valid", 32'(instr_valid), 32'd0);
    chk("r4_async_pc", PC, 32'd0);
    chk("r4_async_addr", imem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    instr_ready = 1'b1;
    drain(10);
    instr_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
